// File: rtl/fphub_div_operand_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fphub_div_operand_classifier: FPHUB divider input stage; tags X/Y with    |
// | special-case codes. Optional skid buffer: FPHUB_DIV_CLASSIFIER_SKID_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fphub_div_operand_classifier #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  localparam int CW          = $clog2(special_case),
  localparam int W           = E + M + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_X,
  input  logic [W-1:0]  in_Y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_X,
  output logic [W-1:0]  out_Y,
  output logic [CW-1:0] out_X_special_case,
  output logic [CW-1:0] out_Y_special_case,
  output logic          out_is_special
);

  localparam logic [CW-1:0] c_case_none   = CW'(0);
  localparam logic [CW-1:0] c_case_inf_p  = CW'(1);
  localparam logic [CW-1:0] c_case_inf_n  = CW'(2);
  localparam logic [CW-1:0] c_case_zero_p = CW'(3);
  localparam logic [CW-1:0] c_case_zero_n = CW'(4);
  localparam logic [CW-1:0] c_case_one_p  = CW'(5);
  localparam logic [CW-1:0] c_case_one_n  = CW'(6);
  localparam logic [E-1:0]  c_bias        = {1'b0, {(E-1){1'b1}}};

  // HUB has no NaN and flushes denormals, so the exponent alone decides INF/ZERO.
  function automatic logic [CW-1:0] classify(input logic [W-1:0] op);
    logic         sgn;
    logic [E-1:0] ex;
    logic [M-1:0] mant;
    sgn  = op[W-1];
    ex   = op[W-2:M];
    mant = op[M-1:0];
    if (&ex)
      classify = sgn ? c_case_inf_n : c_case_inf_p;
    else if (ex == '0)
      classify = sgn ? c_case_zero_n : c_case_zero_p;
    else if ((ex == c_bias) && (mant == '0))
      classify = sgn ? c_case_one_n : c_case_one_p;
    else
      classify = c_case_none;
  endfunction

  logic [CW-1:0] w_x_case;
  logic [CW-1:0] w_y_case;
  logic          w_is_special;
  logic          w_in_fire;

  assign w_x_case     = classify(in_X);
  assign w_y_case     = classify(in_Y);
  assign w_is_special = (w_x_case != c_case_none) || (w_y_case != c_case_none);
  assign w_in_fire    = in_valid && in_ready;

  logic          r_out_valid;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [CW-1:0] r_x_case;
  logic [CW-1:0] r_y_case;
  logic          r_is_special;

`ifdef FPHUB_DIV_CLASSIFIER_SKID_EN
  logic          r_in_ready;
  logic          r_skid_valid;
  logic [W-1:0]  r_skid_x;
  logic [W-1:0]  r_skid_y;
  logic [CW-1:0] r_skid_x_case;
  logic [CW-1:0] r_skid_y_case;
  logic          r_skid_is_special;
  logic          w_main_free;

  assign w_main_free = !r_out_valid || out_ready;
  assign in_ready    = r_in_ready;

  // The skid entry always drains into main before a new pair is taken,
  // which keeps order and lets in_ready be a plain flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready        <= 1'b0;
      r_out_valid       <= 1'b0;
      r_x               <= '0;
      r_y               <= '0;
      r_x_case          <= '0;
      r_y_case          <= '0;
      r_is_special      <= 1'b0;
      r_skid_valid      <= 1'b0;
      r_skid_x          <= '0;
      r_skid_y          <= '0;
      r_skid_x_case     <= '0;
      r_skid_y_case     <= '0;
      r_skid_is_special <= 1'b0;
    end else if (w_main_free) begin
      r_in_ready <= 1'b1;
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_x          <= r_skid_x;
        r_y          <= r_skid_y;
        r_x_case     <= r_skid_x_case;
        r_y_case     <= r_skid_y_case;
        r_is_special <= r_skid_is_special;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid  <= 1'b1;
        r_x          <= in_X;
        r_y          <= in_Y;
        r_x_case     <= w_x_case;
        r_y_case     <= w_y_case;
        r_is_special <= w_is_special;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_in_ready        <= 1'b0;
      r_skid_valid      <= 1'b1;
      r_skid_x          <= in_X;
      r_skid_y          <= in_Y;
      r_skid_x_case     <= w_x_case;
      r_skid_y_case     <= w_y_case;
      r_skid_is_special <= w_is_special;
    end
  end
`else
  logic r_active;

  // r_active holds in_ready low until the first edge after reset release.
  assign in_ready = r_active && (!r_out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_x_case     <= '0;
      r_y_case     <= '0;
      r_is_special <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_in_fire) begin
        r_out_valid  <= 1'b1;
        r_x          <= in_X;
        r_y          <= in_Y;
        r_x_case     <= w_x_case;
        r_y_case     <= w_y_case;
        r_is_special <= w_is_special;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
`endif

  assign out_valid          = r_out_valid;
  assign out_X              = r_x;
  assign out_Y              = r_y;
  assign out_X_special_case = r_x_case;
  assign out_Y_special_case = r_y_case;
  assign out_is_special     = r_is_special;

endmodule
`default_nettype wire

// File: tb/tb_fphub_div_operand_classifier.sv
`default_nettype none
// Randomized and directed bench for fphub_div_operand_classifier against a
// queue-based reference model of the stage.
module tb_fphub_div_operand_classifier;

`ifdef FPHUB_DIV_CLASSIFIER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_X = '0;
  logic [31:0] in_Y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_X;
  logic [31:0] out_Y;
  logic [2:0]  out_X_special_case;
  logic [2:0]  out_Y_special_case;
  logic        out_is_special;

  fphub_div_operand_classifier dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_X               (in_X),
    .in_Y               (in_Y),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_X              (out_X),
    .out_Y              (out_Y),
    .out_X_special_case (out_X_special_case),
    .out_Y_special_case (out_Y_special_case),
    .out_is_special     (out_is_special)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } pair_t;

  pair_t q[$];
  bit    active = 1'b0;
  bit    obs_rdy;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference classification straight from the field values.
  function automatic int code_of(input logic [31:0] v);
    int ex, mant, s;
    ex   = int'((v >> 23) & 32'hFF);
    mant = int'(v & 32'h7FFFFF);
    s    = int'(v >> 31);
    if (ex == 255) return 1 + s;
    if (ex == 0) return 3 + s;
    if (ex == 127 && mant == 0) return 5 + s;
    return 0;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] mant;
    logic        s;
    s    = 1'($urandom_range(0, 1));
    mant = 23'($urandom);
    case ($urandom_range(0, 4))
      0: ex = 8'hFF;
      1: begin ex = 8'h00; if ($urandom_range(0, 1) == 0) mant = '0; end
      2: begin ex = 8'd127; mant = '0; end
      3: ex = 8'd127;
      default: ex = 8'($urandom);
    endcase
    return {s, ex, mant};
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step(output bit acc);
    bit    exp_rdy, of;
    pair_t p;
    @(negedge clk);
    exp_rdy = active && (SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
    obs_rdy = in_ready;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (q.size() > 0) begin
      check("out_X", 64'(out_X), 64'(q[0].x));
      check("out_Y", 64'(out_Y), 64'(q[0].y));
      check("x_case", 64'(out_X_special_case), 64'(code_of(q[0].x)));
      check("y_case", 64'(out_Y_special_case), 64'(code_of(q[0].y)));
      check("is_special", 64'(out_is_special),
            64'((code_of(q[0].x) != 0) || (code_of(q[0].y) != 0)));
    end
    acc = in_valid && exp_rdy;
    of  = (q.size() > 0) && out_ready;
    p.x = in_X;
    p.y = in_Y;
    @(posedge clk);
    #1;
    if (of) void'(q.pop_front());
    if (acc) q.push_back(p);
    if (rst_n) active = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] y,
                       input bit ordy, output bit acc);
    in_valid  = v;
    in_X      = v ? x : 32'($urandom);
    in_Y      = v ? y : 32'($urandom);
    out_ready = ordy;
    step(acc);
  endtask

  initial begin
    bit          acc;
    int          n_abs;
    logic [31:0] px[4];
    logic [31:0] py[4];
    logic        cv;
    logic [31:0] cx, cy;

    // Reset state
    drive(0, 0, 0, 1, acc);
    check("rst_out_X", 64'(out_X), 64'h0);
    check("rst_x_case", 64'(out_X_special_case), 64'h0);
    check("rst_special", 64'(out_is_special), 64'h0);
    drive(0, 0, 0, 1, acc);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, acc);

    // Classification vectors
    drive(1, 32'h3F800000, 32'hBF800000, 1, acc);
    check("clsA_xc", 64'(out_X_special_case), 64'd5);
    check("clsA_yc", 64'(out_Y_special_case), 64'd6);
    check("clsA_sp", 64'(out_is_special), 64'd1);
    drive(1, 32'h40400000, 32'h40A00000, 1, acc);
    check("clsB_xc", 64'(out_X_special_case), 64'd0);
    check("clsB_sp", 64'(out_is_special), 64'd0);
    check("clsB_valid", 64'(out_valid), 64'd1);
    drive(1, 32'hFF800000, 32'h00000001, 1, acc);
    check("clsC_xc", 64'(out_X_special_case), 64'd2);
    check("clsC_yc", 64'(out_Y_special_case), 64'd3);
    drive(0, 0, 0, 1, acc);

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      logic [31:0] bx, by;
      bx = rand_op() ^ 32'(i);
      by = rand_op();
      drive(1, bx, by, 1, acc);
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_X", 64'(out_X), 64'(bx));
    end
    drive(0, 0, 0, 1, acc);

    // Backpressure with a pending pair
    for (int i = 0; i < 4; i++) begin
      px[i] = rand_op();
      py[i] = rand_op();
    end
    drive(1, px[0], py[0], 1, acc);
    n_abs = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1, px[1 + n_abs], py[1 + n_abs], 0, acc);
      if (in_valid && obs_rdy) n_abs++;
      check("stall_hold_X", 64'(out_X), 64'(px[0]));
      check("stall_hold_Y", 64'(out_Y), 64'(py[0]));
    end
    check("stall_absorbed", 64'(n_abs), SKID ? 64'd1 : 64'd0);
    for (int c = 0; c < 3; c++) drive(0, 0, 0, 1, acc);
    check("stall_drained", 64'(out_valid), 64'd0);

    // Reset asserted mid-stall
    drive(1, 32'h3F800000, 32'h7F800000, 1, acc);
    drive(0, 0, 0, 0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_X", 64'(out_X), 64'd0);
    check("mrst_Y", 64'(out_Y), 64'd0);
    check("mrst_codes", 64'({out_X_special_case, out_Y_special_case}), 64'd0);
    check("mrst_special", 64'(out_is_special), 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd0);
    q.delete();
    active = 1'b0;
    drive(1, 32'h3F800000, 32'h3F800000, 1, acc);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, acc);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    drive(1, 32'hBF800000, 32'h80000000, 1, acc);
    check("post_rst_xc", 64'(out_X_special_case), 64'd6);
    check("post_rst_yc", 64'(out_Y_special_case), 64'd4);

    // Randomized traffic; the source holds a pair until it is taken
    cv = 1'b0;
    cx = '0;
    cy = '0;
    for (int c = 0; c < 400; c++) begin
      if (!cv) begin
        cv = ($urandom_range(0, 3) != 0);
        cx = rand_op();
        cy = rand_op();
      end
      drive(cv, cx, cy, $urandom_range(0, 9) < 7, acc);
      if (acc) cv = 1'b0;
    end
    for (int c = 0; c < 4; c++) drive(0, 0, 0, 1, acc);
    check("final_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fphub_div_operand_classifier.md
Name: fphub_div_operand_classifier

Overview:
- Input stage of the FPHUB divider, directly upstream of the special-result generator.
- Accepts an operand pair (X, Y) through a valid/ready handshake and classifies each operand into the divider's special-case code.
- Registers the operands and codes, then presents them downstream with a valid/ready handshake.
- Downstream logic uses out_is_special to choose between the special-result path and the iterative mantissa divider.

Parameters:
- M, 23, mantissa width.
- E, 8, exponent width.
- special_case, 7, number of special-case codes including CASE_NONE. Code width is CW = $clog2(special_case).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair on in_X/in_Y is valid.
- in_ready  output  1  stage can accept a pair this cycle.
- in_X  input  E+M+1  dividend, HUB format {sign, exp[E-1:0], mant[M-1:0]}.
- in_Y  input  E+M+1  divisor, same format.
- out_valid  output  1  registered pair is available.
- out_ready  input  1  downstream accepts the pair.
- out_X  output  E+M+1  registered dividend.
- out_Y  output  E+M+1  registered divisor.
- out_X_special_case  output  CW  code for X.
- out_Y_special_case  output  CW  code for Y.
- out_is_special  output  1  high when either code is non-zero.

Behaviour:
- Codes: NONE=0, INF_P=1, INF_N=2, ZERO_P=3, ZERO_N=4, ONE_P=5, ONE_N=6.
- Classification of each operand is combinational on the input, checked in priority order:
  - exp all ones, mantissa any value -> INF. HUB has no NaN.
  - exp all zeros, mantissa any value -> ZERO. Denormals are flushed.
  - exp == 2^(E-1)-1 and mant == 0 -> ONE.
  - otherwise -> NONE.
  - The sign bit selects the _P or _N code. The sign is ignored for NONE.
- Codes are computed before the register, so outputs carry no combinational path from the inputs.
- A transfer occurs on any edge where valid && ready on the relevant side.
- Latency: 1 cycle. A pair accepted on edge n has out_valid=1 after edge n.
- Throughput: 1 pair per cycle when out_ready is held high.
- out_valid stays high and the out_* fields stay stable until the downstream transfer completes (AXI-style hold).
- Reset (asserted at any time, including mid-transfer):
  - out_valid=0.
  - out_X, out_Y, both codes and out_is_special all 0.
  - Any buffered pair is discarded.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after deassertion.
- Simultaneous accept and drain when full: the new pair replaces the outgoing one on the same edge, with no bubble.
- in_X/in_Y are ignored whenever in_valid=0. Registers do not change when no transfer occurs.

Optional Feature:
- Macro: FPHUB_DIV_CLASSIFIER_SKID_EN.
- Defined:
  - A 2-entry skid buffer (main + skid register) is used.
  - in_ready is a registered flop output: high when the skid entry is empty.
  - If out_ready is low while a pair is accepted, that pair goes to the skid entry and in_ready drops on the next cycle.
  - Order is preserved; the skid entry drains before any new pair is taken.
- Undefined:
  - A single register stage is used, with in_ready = !out_valid || out_ready (combinational from out_ready).
- Latency of 1 cycle and all functional results are identical in both builds.

Test Plan:
- Classification, M=23, E=8, out_ready=1:
  - X=0x3F800000, Y=0xBF800000 -> codes 5/6, out_is_special=1, one cycle after the accept.
  - X=0x40400000, Y=0x40A00000 -> codes 0/0, out_is_special=0.
  - X=0xFF800000 (INF_N), Y=0x00000001 (flushed zero, ZERO_P) -> codes 2/3, out_is_special=1.
- Back-to-back stream of 8 distinct pairs with out_ready=1 throughout:
  - in_ready stays 1 and out_valid stays 1 after the first pair.
  - Pairs emerge in order with no bubbles.
- Backpressure: out_ready=0 for 3 cycles while a pair is pending:
  - out_* hold stable.
  - Without the macro, in_ready=0 during the stall.
  - With the macro, exactly one extra pair is absorbed, then in_ready=0.
  - Both pairs drain in order once out_ready=1.
- Full plus simultaneous accept/drain: out_valid=1, out_ready=1 and in_valid=1 on the same edge:
  - The new pair appears on the next cycle with out_valid held at 1.
- Reset mid-stall: assert rst_n=0 asynchronously between edges while out_valid=1:
  - out_valid=0 and all data outputs 0 immediately.
  - After release, in_ready=1 and the first new pair passes normally.
